fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 71 +++++++
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared definitions for the instruction fetch unit and the
//                decoder that consumes its output: FSM state encoding,
//                4-bit opcode constants, instruction field positions and
//                the branch-class test.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

   // ------------------------------------------------------------------------
   // Instruction word geometry
   // ------------------------------------------------------------------------
   localparam int INSTR_W = 16;
   localparam int OPC_W   = 4;

   // Field positions shared with the decoder
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS_MSB  = 7;
   localparam int RS_LSB  = 4;
   localparam int RT_MSB  = 3;
   localparam int RT_LSB  = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef logic [OPC_W-1:0]   opcode_t;
   typedef logic [INSTR_W-1:0] instr_word_t;

   // Register-form view of an instruction word
   typedef struct packed {
      opcode_t    opc;
      logic [3:0] rd;
      logic [3:0] rs;
      logic [3:0] rt;
   } instr_fields_t;

   // ------------------------------------------------------------------------
   // Opcode map
   // ------------------------------------------------------------------------
   localparam opcode_t OPC_NOP   = 4'b0000;
   localparam opcode_t OPC_ADD   = 4'b0001;
   localparam opcode_t OPC_SUB   = 4'b0010;
   localparam opcode_t OPC_AND   = 4'b0011;
   localparam opcode_t OPC_OR    = 4'b0100;
   localparam opcode_t OPC_LDI   = 4'b0101;
   localparam opcode_t OPC_LOAD  = 4'b0110;
   localparam opcode_t OPC_STORE = 4'b0111;
   localparam opcode_t OPC_BRZ   = 4'b1100;   // branch class
   localparam opcode_t OPC_BRNZ  = 4'b1101;   // branch class

   // ------------------------------------------------------------------------
   // FSM state encoding
   // ------------------------------------------------------------------------
   localparam int ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [ST_W-1:0] ST_FETCH  = 2'd1;
   localparam logic [ST_W-1:0] ST_ISSUE  = 2'd2;
   localparam logic [ST_W-1:0] ST_BRWAIT = 2'd3;

   // Branch-class instructions stall fetch until execute resolves them.
   function automatic logic is_branch(input opcode_t opcode);
      return (opcode == OPC_BRZ) || (opcode == OPC_BRNZ);
   endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction memory read bus between the fetch unit
//                (master) and the instruction memory (slave).
//  Signals     : mem_req   - read request, held until acknowledged
//                mem_addr  - read address
//                mem_ack   - one-cycle completion, mem_rdata valid with it
//                mem_rdata - 16-bit instruction word
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
   parameter int ADDR_W = 16
);
   import fetch_unit_pkg::*;

   logic                mem_req;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_ack;
   instr_word_t         mem_rdata;

   // Fetch unit side
   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   // Memory side
   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Single-issue instruction fetch unit. Reads one instruction
//                word at pc, latches it, presents it to the decoder for one
//                decode_enable cycle, then either fetches the next word or
//                waits for the execute stage to resolve a branch.
//
//  Ports       : clk            - clock, rising edge
//                reset_n        - synchronous active-low reset
//                run            - level, permits fetching
//                stall          - downstream busy, holds the issued word
//                bus            - instruction memory bus (master side)
//                instruction    - latched instruction word
//                decode_enable  - decoder capture strobe
//                branch_resolve - pulse, outstanding branch resolved
//                branch_taken   - qualifies branch_resolve
//                branch_target  - redirect address
//                pc             - address of the next fetch
//                busy           - high in every state except IDLE
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                 ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  wire logic                clk,
   input  wire logic                reset_n,

   input  wire logic                run,
   input  wire logic                stall,

   fetch_unit_if.master             bus,

   output      logic [INSTR_W-1:0]  instruction,
   output      logic                decode_enable,

   input  wire logic                branch_resolve,
   input  wire logic                branch_taken,
   input  wire logic [ADDR_W-1:0]   branch_target,

   output      logic [ADDR_W-1:0]   pc,
   output      logic                busy
);

   localparam logic [ADDR_W-1:0]  c_PC_STEP   = ADDR_W'(1);
   localparam logic [INSTR_W-1:0] c_INSTR_RST = '0;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [ST_W-1:0]     r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [INSTR_W-1:0]  r_instr;

   logic [ST_W-1:0]     w_state_nxt;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic [INSTR_W-1:0]  w_instr_nxt;
   logic                w_is_branch;

   assign w_is_branch = is_branch(r_instr[OPC_MSB:OPC_LSB]);

   // ------------------------------------------------------------------------
   // Next-state logic
   //
   // mem_ack and branch_resolve are only looked at in the state that owns
   // them, so stray pulses elsewhere (including an ack for a request that a
   // reset abandoned) fall through with no effect.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;

      case (r_state)
         ST_IDLE: begin
            if (run) begin
               w_state_nxt = ST_FETCH;
            end
         end

         // run is deliberately not examined here: an outstanding request
         // always completes and its word is always issued.
         ST_FETCH: begin
            if (bus.mem_ack) begin
               w_instr_nxt = bus.mem_rdata;
               w_pc_nxt    = r_pc + c_PC_STEP;   // wraps modulo 2^ADDR_W
               w_state_nxt = ST_ISSUE;
            end
         end

         // The word is handed over in the cycle stall is low; the exit
         // decision uses run sampled in that same cycle.
         ST_ISSUE: begin
            if (!stall) begin
               if (w_is_branch) begin
                  w_state_nxt = ST_BRWAIT;
               end else if (run) begin
                  w_state_nxt = ST_FETCH;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end

         // pc already points past the branch; overwrite it only when taken.
         ST_BRWAIT: begin
            if (branch_resolve) begin
               if (branch_taken) begin
                  w_pc_nxt = branch_target;
               end
               w_state_nxt = run ? ST_FETCH : ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
         r_instr <= c_INSTR_RST;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   //
   // mem_req is a pure state decode, so it stays high for the whole FETCH
   // residency (i.e. until acknowledged). decode_enable follows stall
   // combinationally so the decoder captures in the very cycle stall drops.
   // ------------------------------------------------------------------------
   assign bus.mem_req   = (r_state == ST_FETCH);
   assign bus.mem_addr  = r_pc;
   assign instruction   = r_instr;
   assign decode_enable = (r_state == ST_ISSUE) && !stall;
   assign pc            = r_pc;
   assign busy          = (r_state != ST_IDLE);

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Randomised scoreboard bench for fetch_unit. The reference
//                model is a program-order walk over a memory image: every
//                acknowledged fetch pushes the word at the model pc, branch
//                resolutions move the model pc, and the monitor pops one
//                entry per decode_enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam int          AW     = 16;
   localparam logic [15:0] RST_PC = 16'h0010;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          run;
   logic          stall;
   logic [15:0]   instruction;
   logic          decode_enable;
   logic          branch_resolve;
   logic          branch_taken;
   logic [15:0]   branch_target;
   logic [15:0]   pc;
   logic          busy;

   always #5 clk = ~clk;

   fetch_unit_if #(.ADDR_W(AW)) bus ();

   fetch_unit #(
      .ADDR_W   (AW),
      .RESET_PC (RST_PC)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .run            (run),
      .stall          (stall),
      .bus            (bus),
      .instruction    (instruction),
      .decode_enable  (decode_enable),
      .branch_resolve (branch_resolve),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .pc             (pc),
      .busy           (busy)
   );

   // ------------------------------------------------------------------------
   // Scoreboard state
   // ------------------------------------------------------------------------
   typedef struct {
      logic [15:0] addr;
      logic [15:0] word;
      int          cyc;
      int          ep;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] mem [0:65535];
   logic [15:0] m_pc;
   int          cyc      = 0;
   int          epoch    = 0;
   int          br_seen  = 0;   // branches decoded (monitor)
   int          br_done  = 0;   // branches resolved (driver)
   int          n_dec    = 0;
   int          n_cmp    = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;
   bit          directed = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)",
                  name, act, req, cyc);
      end
   endtask

   function automatic bit model_is_branch(input logic [15:0] w);
      return w[15:13] == 3'b110;
   endfunction

   function automatic logic [15:0] pick_target();
      case ($urandom_range(0, 3))
         0:       return 16'hFFFF;
         1:       return 16'hFFFE;
         2:       return 16'h0040;
         default: return 16'($urandom);
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Driver helpers
   // ------------------------------------------------------------------------
   task automatic reset_seq();
      @(posedge clk); cyc++; #1;
      reset_n        = 1'b0;
      stall          = 1'b1;       // no hand-over in the reset cycle
      run            = 1'($urandom_range(0, 1));
      bus.mem_ack    = 1'b0;
      branch_resolve = 1'b0;
      epoch++;
      br_done        = br_seen;
      m_pc           = RST_PC;

      // First cycle out of reset: spurious ack with run low
      @(posedge clk); cyc++; #1;
      mon_en         = 1'b1;
      reset_n        = 1'b1;
      run            = 1'b0;
      stall          = 1'b0;
      bus.mem_ack    = 1'b1;
      bus.mem_rdata  = 16'($urandom);
      check("rst_busy",    busy,          0);
      check("rst_instr",   instruction,   0);
      check("rst_pc",      pc,            RST_PC);
      check("rst_mem_req", bus.mem_req,   0);
      check("rst_dec_en",  decode_enable, 0);

      @(posedge clk); cyc++; #1;
      bus.mem_ack    = 1'b0;
      check("post_rst_ack_busy",  busy,        0);
      check("post_rst_ack_instr", instruction, 0);
      check("post_rst_ack_pc",    pc,          RST_PC);
   endtask

   // mode 0: zero-wait, no stall, run high, immediate resolve
   // mode 1: randomised timing with spurious ack / resolve pulses
   // mode 2: drain (run low, always ack, immediate resolve)
   task automatic step(input int mode);
      bit pending;
      @(posedge clk); cyc++; #1;
      reset_n        = 1'b1;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = 16'($urandom);
      branch_resolve = 1'b0;
      branch_taken   = 1'($urandom_range(0, 1));
      branch_target  = 16'($urandom);
      pending        = (br_seen != br_done);

      case (mode)
         0:       begin run = 1'b1; stall = 1'b0; end
         1:       begin
                     run   = ($urandom_range(0, 9) != 0);
                     stall = ($urandom_range(0, 9) < 3);
                  end
         default: begin run = 1'b0; stall = 1'b0; end
      endcase

      if (pending && (mode != 1 || $urandom_range(0, 2) == 0)) begin
         branch_resolve = 1'b1;
         branch_target  = pick_target();
         if (branch_taken) m_pc = branch_target;
         br_done++;
      end else if (!pending && mode == 1 && $urandom_range(0, 9) == 0) begin
         branch_resolve = 1'b1;     // must be ignored
      end

      if (bus.mem_req) begin
         if (mode != 1 || $urandom_range(0, 9) < 6) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr];
            exp_q.push_back('{addr: m_pc, word: mem[m_pc], cyc: cyc, ep: epoch});
            m_pc = m_pc + 16'd1;
         end
      end else if (mode == 1 && $urandom_range(0, 9) == 0) begin
         bus.mem_ack = 1'b1;        // must be ignored
      end
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      reset_n        = 1'b0;
      run            = 1'b0;
      stall          = 1'b0;
      branch_resolve = 1'b0;
      branch_taken   = 1'b0;
      branch_target  = '0;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = '0;
      m_pc           = RST_PC;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[RST_PC] = 16'h1234;

      reset_seq();
      directed = 1'b1;
      repeat (60) step(0);
      directed = 1'b0;

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 249) == 0) reset_seq();
         else                             step(1);
      end

      for (int i = 0; i < 100; i++) begin
         step(2);
         if (exp_q.size() == 0 && br_seen == br_done && !busy) break;
      end
      step(2);
      step(2);
      check("scoreboard_drained", exp_q.size(), 0);
      check("idle_after_drain",   busy,         0);
      check("enough_decodes",     (n_dec >= 300), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   initial begin
      int          nxt_kind = 0;   // 1 expect req, 2 expect brwait, 3 expect idle
      int          last_dec = -1;
      bit          last_br  = 1'b0;
      int          mon_ep   = 0;
      bit          in_issue;
      exp_t        e;
      logic [15:0] pc_exp;

      forever begin
         @(negedge clk);
         if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].ep != epoch) void'(exp_q.pop_front());
            if (mon_ep != epoch) begin
               mon_ep   = epoch;
               last_dec = -1;
            end

            case (nxt_kind)
               1: check("req_after_issue", bus.mem_req, 1);
               2: begin
                     check("brwait_no_req", bus.mem_req, 0);
                     check("brwait_busy",   busy,        1);
                  end
               3: check("idle_after_issue", busy, 0);
               default: ;
            endcase
            nxt_kind = 0;

            in_issue = (exp_q.size() > 0) && (exp_q[0].cyc < cyc);
            check("decode_enable", decode_enable, 32'(in_issue && !stall));

            if (decode_enable === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL decode_unexpected: actual=decode_enable required=no_issue (cycle %0d)", cyc);
               end else begin
                  e      = exp_q.pop_front();
                  pc_exp = e.addr + 16'd1;
                  check("instruction",    instruction, e.word);
                  check("pc_after_fetch", pc,          pc_exp);
                  if (directed && last_dec >= 0)
                     check("issue_gap", cyc - last_dec, last_br ? 3 : 2);
                  last_dec = cyc;
                  last_br  = model_is_branch(e.word);
                  n_dec++;
                  if (last_br) begin
                     br_seen++;
                     nxt_kind = 2;
                  end else begin
                     nxt_kind = run ? 1 : 3;
                  end
               end
            end
         end
      end
   end

endmodule : tb_fetch_unit
`default_nettype wire
